// File: rtl/pulse_sched_arb.sv
// pulse_sched_arb
// Round-robin scheduler that shares one stretched pulse line among N event
// requesters. Rising edges on req are captured as pending requests and
// serviced one at a time: a pulse of programmable width, then an optional
// minimum gap, then at least one idle cycle before the next grant.
module pulse_sched_arb #(
   parameter int    N        = 4,
   parameter int    CW       = 8,
   parameter int    IDW      = 2,
   parameter string POLARITY = "HIGH"
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic [N-1:0]   req,
   input  logic [CW-1:0]  cfg_width,
   input  logic [CW-1:0]  cfg_gap,
   input  logic           drop_clr,
   output logic           pulse_out,
   output logic [IDW-1:0] pulse_id,
   output logic [N-1:0]   ack,
   output logic           busy,
   output logic [N-1:0]   pending,
   output logic [15:0]    drop_cnt
);

   // Index width needed to address one of the N channels
   localparam int   PW      = (N > 1) ? $clog2(N) : 1;
   // Active level of pulse_out; the idle level is its inverse
   localparam logic ACT_LVL = (POLARITY == "LOW") ? 1'b0 : 1'b1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PULSE = 2'd1,
      GAP   = 2'd2
   } state_t;

   state_t         state;
   state_t         state_nxt;
   logic [N-1:0]   req_d;
   logic [N-1:0]   rise;
   logic [PW-1:0]  rr_ptr;
   logic [PW-1:0]  rr_nxt;
   logic [CW-1:0]  cnt;
   logic [CW-1:0]  cnt_nxt;
   logic [CW-1:0]  width_l;
   logic [CW-1:0]  width_nxt;
   logic [CW-1:0]  gap_l;
   logic [CW-1:0]  gap_nxt;
   logic [CW-1:0]  w_eff;
   logic [IDW-1:0] id_nxt;
   logic [N-1:0]   pending_nxt;
   logic [15:0]    drop_cnt_nxt;
   logic [N-1:0]   grant_vec;
   logic           grant;
   logic           drop_any;
   logic           found;
   logic [PW-1:0]  win_id;
   logic [PW:0]    scan;

   // Saturating increment for the 16-bit drop counter
   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   // One new event per low-to-high transition; a held level is a single event
   assign rise  = req & ~req_d;

   // A programmed width of zero still produces a one-cycle pulse
   assign w_eff = (width_l == '0) ? CW'(1) : width_l;

   // Round-robin search: first pending channel after rr_ptr, wrapping modulo N
   always_comb begin
      found  = 1'b0;
      win_id = '0;
      scan   = '0;
      for (int k = 1; k <= N; k++) begin
         scan = {1'b0, rr_ptr} + (PW+1)'(k);
         if (scan >= (PW+1)'(N)) begin
            scan = scan - (PW+1)'(N);
         end
         if (!found && pending[scan[PW-1:0]]) begin
            found  = 1'b1;
            win_id = scan[PW-1:0];
         end
      end
   end

   // Next-state logic: grant in IDLE, count pulse width then gap, track drops
   always_comb begin
      state_nxt    = state;
      cnt_nxt      = cnt;
      width_nxt    = width_l;
      gap_nxt      = gap_l;
      rr_nxt       = rr_ptr;
      id_nxt       = pulse_id;
      grant        = 1'b0;
      case (state)
         IDLE: begin
            if (found) begin
               grant     = 1'b1;
               state_nxt = PULSE;
               cnt_nxt   = CW'(1);
               width_nxt = cfg_width;
               gap_nxt   = cfg_gap;
               rr_nxt    = win_id;
               id_nxt    = IDW'(win_id);
            end
         end
         PULSE: begin
            // cnt holds the index of the pulse cycle currently being driven
            if (cnt >= w_eff) begin
               if (gap_l != '0) begin
                  state_nxt = GAP;
                  cnt_nxt   = CW'(1);
               end else begin
                  state_nxt = IDLE;
                  cnt_nxt   = '0;
               end
            end else begin
               cnt_nxt = cnt + CW'(1);
            end
         end
         GAP: begin
            if (cnt >= gap_l) begin
               state_nxt = IDLE;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + CW'(1);
            end
         end
         default: begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
         end
      endcase

      grant_vec = grant ? (N'(1) << win_id) : '0;

      // A rise on an already-pending channel that is not being granted is lost;
      // a rise on the channel being granted re-arms it as a fresh event
      drop_any    = |(rise & pending & ~grant_vec);
      pending_nxt = (pending & ~grant_vec) | rise;

      if (drop_clr) begin
         drop_cnt_nxt = '0;
      end else if (drop_any) begin
         drop_cnt_nxt = sat_inc16(drop_cnt);
      end else begin
         drop_cnt_nxt = drop_cnt;
      end
   end

   // State, request history, latched configuration and registered outputs
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         pending   <= '0;
         req_d     <= '0;
         rr_ptr    <= PW'(N-1);
         cnt       <= '0;
         width_l   <= '0;
         gap_l     <= '0;
         pulse_out <= ~ACT_LVL;
         pulse_id  <= '0;
         ack       <= '0;
         busy      <= 1'b0;
         drop_cnt  <= '0;
      end else begin
         state     <= state_nxt;
         pending   <= pending_nxt;
         req_d     <= req;
         rr_ptr    <= rr_nxt;
         cnt       <= cnt_nxt;
         width_l   <= width_nxt;
         gap_l     <= gap_nxt;
         pulse_out <= (state_nxt == PULSE) ? ACT_LVL : ~ACT_LVL;
         pulse_id  <= id_nxt;
         ack       <= grant_vec;
         busy      <= (state_nxt != IDLE);
         drop_cnt  <= drop_cnt_nxt;
      end
   end

endmodule

// File: tb/tb_pulse_sched_arb.sv
// Testbench for pulse_sched_arb: directed scenarios plus a randomized run
// against a timeline-based reference model.
module tb_pulse_sched_arb;

   localparam int N   = 4;
   localparam int CW  = 8;
   localparam int IDW = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // Active-high instance
   logic           rst_n;
   logic [N-1:0]   req;
   logic [CW-1:0]  cfg_width;
   logic [CW-1:0]  cfg_gap;
   logic           drop_clr;
   logic           pulse_out;
   logic [IDW-1:0] pulse_id;
   logic [N-1:0]   ack;
   logic           busy;
   logic [N-1:0]   pending;
   logic [15:0]    drop_cnt;

   // Active-low instance
   logic           lo_rst_n;
   logic [N-1:0]   lo_req;
   logic [CW-1:0]  lo_cfg_width;
   logic [CW-1:0]  lo_cfg_gap;
   logic           lo_drop_clr;
   logic           lo_pulse_out;
   logic [IDW-1:0] lo_pulse_id;
   logic [N-1:0]   lo_ack;
   logic           lo_busy;
   logic [N-1:0]   lo_pending;
   logic [15:0]    lo_drop_cnt;

   int checks = 0;
   int errors = 0;

   pulse_sched_arb #(.N(N), .CW(CW), .IDW(IDW), .POLARITY("HIGH")) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .cfg_width(cfg_width), .cfg_gap(cfg_gap),
      .drop_clr(drop_clr), .pulse_out(pulse_out), .pulse_id(pulse_id), .ack(ack),
      .busy(busy), .pending(pending), .drop_cnt(drop_cnt)
   );

   pulse_sched_arb #(.N(N), .CW(CW), .IDW(IDW), .POLARITY("LOW")) dut_lo (
      .clk(clk), .rst_n(lo_rst_n), .req(lo_req), .cfg_width(lo_cfg_width), .cfg_gap(lo_cfg_gap),
      .drop_clr(lo_drop_clr), .pulse_out(lo_pulse_out), .pulse_id(lo_pulse_id), .ack(lo_ack),
      .busy(lo_busy), .pending(lo_pending), .drop_cnt(lo_drop_cnt)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; req = '0; cfg_width = 8'd3; cfg_gap = 8'd2; drop_clr = 1'b0;
      tick(); tick();
      checks++; if (pulse_out !== 1'b0) begin errors++; $display("FAIL reset_pulse_out: got %b expected 0", pulse_out); end
      checks++; if (pending !== 4'b0000) begin errors++; $display("FAIL reset_pending: got %b expected 0000", pending); end
      checks++; if (pulse_id !== 2'd0) begin errors++; $display("FAIL reset_pulse_id: got %0d expected 0", pulse_id); end
      checks++; if (ack !== 4'b0000) begin errors++; $display("FAIL reset_ack: got %b expected 0000", ack); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
      checks++; if (drop_cnt !== 16'd0) begin errors++; $display("FAIL reset_drop_cnt: got %0d expected 0", drop_cnt); end
   endtask

   task automatic test_single();
      logic       ep;
      logic       eb;
      logic [3:0] ea;
      rst_n = 1'b1; cfg_width = 8'd3; cfg_gap = 8'd2; req = '0;
      tick();
      req = 4'b0100;
      tick();
      req = 4'b0000;
      checks++; if (pending !== 4'b0100) begin errors++; $display("FAIL single_pending: got %b expected 0100", pending); end
      checks++; if (pulse_out !== 1'b0) begin errors++; $display("FAIL single_pre_pulse: got %b expected 0", pulse_out); end
      for (int off = 0; off < 8; off++) begin
         tick();
         ep = (off < 3);
         eb = (off < 5);
         ea = (off == 0) ? 4'b0100 : 4'b0000;
         checks++; if (pulse_out !== ep) begin errors++; $display("FAIL single_pulse_off%0d: got %b expected %b", off, pulse_out, ep); end
         checks++; if (busy !== eb) begin errors++; $display("FAIL single_busy_off%0d: got %b expected %b", off, busy, eb); end
         checks++; if (ack !== ea) begin errors++; $display("FAIL single_ack_off%0d: got %b expected %b", off, ack, ea); end
         checks++; if (pulse_id !== 2'd2) begin errors++; $display("FAIL single_id_off%0d: got %0d expected 2", off, pulse_id); end
      end
      checks++; if (drop_cnt !== 16'd0) begin errors++; $display("FAIL single_drop_cnt: got %0d expected 0", drop_cnt); end
   endtask

   task automatic test_rr_order();
      logic [3:0] ep;
      logic [3:0] ea;
      rst_n = 1'b0; tick(); rst_n = 1'b1;
      cfg_width = 8'd1; cfg_gap = 8'd0;
      req = 4'b1111;
      tick();
      checks++; if (pending !== 4'b1111) begin errors++; $display("FAIL rr_pending_init: got %b expected 1111", pending); end
      for (int ch = 0; ch < 4; ch++) begin
         ep = 4'b1111;
         ep = ep << (ch + 1);
         ea = 4'b0001;
         ea = ea << ch;
         tick();
         checks++; if (ack !== ea) begin errors++; $display("FAIL rr_ack_ch%0d: got %b expected %b", ch, ack, ea); end
         checks++; if (pulse_id !== ch[1:0]) begin errors++; $display("FAIL rr_id_ch%0d: got %0d expected %0d", ch, pulse_id, ch); end
         checks++; if (pulse_out !== 1'b1) begin errors++; $display("FAIL rr_pulse_ch%0d: got %b expected 1", ch, pulse_out); end
         checks++; if (pending !== ep) begin errors++; $display("FAIL rr_pending_ch%0d: got %b expected %b", ch, pending, ep); end
         tick();
         checks++; if (pulse_out !== 1'b0) begin errors++; $display("FAIL rr_gap_ch%0d: got %b expected 0", ch, pulse_out); end
         checks++; if (ack !== 4'b0000) begin errors++; $display("FAIL rr_ack_clear_ch%0d: got %b expected 0000", ch, ack); end
      end
      req = 4'b0000;
      tick();
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rr_idle_busy: got %b expected 0", busy); end
   endtask

   task automatic test_drop();
      int n;
      rst_n = 1'b0; tick(); rst_n = 1'b1;
      cfg_width = 8'd4; cfg_gap = 8'd0; drop_clr = 1'b0;
      req = 4'b0001; tick();
      req = 4'b0000; tick();
      req = 4'b0010; tick();
      req = 4'b0000; tick();
      req = 4'b0010; tick();
      req = 4'b0000;
      checks++; if (drop_cnt !== 16'd1) begin errors++; $display("FAIL drop_count: got %0d expected 1", drop_cnt); end
      n = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (ack[1] === 1'b1) n++;
      end
      checks++; if (n !== 1) begin errors++; $display("FAIL drop_serviced_once: got %0d expected 1", n); end
      checks++; if (drop_cnt !== 16'd1) begin errors++; $display("FAIL drop_count_hold: got %0d expected 1", drop_cnt); end
      req = 4'b0001; tick();
      req = 4'b0000; tick();
      req = 4'b0010; tick();
      req = 4'b0000; tick();
      req = 4'b0010; drop_clr = 1'b1; tick();
      req = 4'b0000; drop_clr = 1'b0;
      checks++; if (drop_cnt !== 16'd0) begin errors++; $display("FAIL drop_clr_priority: got %0d expected 0", drop_cnt); end
      checks++; if (pending !== 4'b0010) begin errors++; $display("FAIL drop_pending_kept: got %b expected 0010", pending); end
      for (int i = 0; i < 12; i++) tick();
   endtask

   task automatic test_width();
      int n;
      rst_n = 1'b0; tick(); rst_n = 1'b1;
      cfg_width = 8'd0; cfg_gap = 8'd0;
      req = 4'b0001; tick(); req = 4'b0000;
      n = 0;
      for (int i = 0; i < 10; i++) begin tick(); if (pulse_out === 1'b1) n++; end
      checks++; if (n !== 1) begin errors++; $display("FAIL width_zero: got %0d cycles expected 1", n); end
      cfg_width = 8'd5;
      req = 4'b0010; tick(); req = 4'b0000;
      tick();
      n = (pulse_out === 1'b1) ? 1 : 0;
      cfg_width = 8'd2;
      for (int i = 0; i < 12; i++) begin tick(); if (pulse_out === 1'b1) n++; end
      checks++; if (n !== 5) begin errors++; $display("FAIL width_latched: got %0d cycles expected 5", n); end
      req = 4'b0100; tick(); req = 4'b0000;
      n = 0;
      for (int i = 0; i < 12; i++) begin tick(); if (pulse_out === 1'b1) n++; end
      checks++; if (n !== 2) begin errors++; $display("FAIL width_next: got %0d cycles expected 2", n); end
   endtask

   task automatic test_polarity_low();
      int n;
      lo_rst_n = 1'b0; lo_req = '0; lo_cfg_width = 8'd4; lo_cfg_gap = 8'd1; lo_drop_clr = 1'b0;
      tick();
      lo_rst_n = 1'b1;
      checks++; if (lo_pulse_out !== 1'b1) begin errors++; $display("FAIL low_idle_level: got %b expected 1", lo_pulse_out); end
      lo_req = 4'b0010; tick(); lo_req = 4'b0000;
      n = 0;
      for (int i = 0; i < 12; i++) begin tick(); if (lo_pulse_out === 1'b0) n++; end
      checks++; if (n !== 4) begin errors++; $display("FAIL low_width: got %0d active cycles expected 4", n); end
      lo_req = 4'b1001; tick();
      lo_req = 4'b0000; tick();
      checks++; if (lo_pulse_out !== 1'b0) begin errors++; $display("FAIL low_active: got %b expected 0", lo_pulse_out); end
      checks++; if (lo_pulse_id !== 2'd3) begin errors++; $display("FAIL low_id: got %0d expected 3", lo_pulse_id); end
      checks++; if (lo_ack !== 4'b1000) begin errors++; $display("FAIL low_ack: got %b expected 1000", lo_ack); end
      lo_req = 4'b0001; tick();
      checks++; if (lo_drop_cnt !== 16'd1) begin errors++; $display("FAIL low_drop: got %0d expected 1", lo_drop_cnt); end
      checks++; if (lo_pending !== 4'b0001) begin errors++; $display("FAIL low_pending: got %b expected 0001", lo_pending); end
      lo_rst_n = 1'b0; tick();
      checks++; if (lo_pulse_out !== 1'b1) begin errors++; $display("FAIL low_rst_pulse: got %b expected 1", lo_pulse_out); end
      checks++; if (lo_pending !== 4'b0000) begin errors++; $display("FAIL low_rst_pending: got %b expected 0000", lo_pending); end
      checks++; if (lo_pulse_id !== 2'd0) begin errors++; $display("FAIL low_rst_id: got %0d expected 0", lo_pulse_id); end
      checks++; if (lo_drop_cnt !== 16'd0) begin errors++; $display("FAIL low_rst_drop: got %0d expected 0", lo_drop_cnt); end
      checks++; if (lo_busy !== 1'b0) begin errors++; $display("FAIL low_rst_busy: got %b expected 0", lo_busy); end
   endtask

   // Reference model: each grant opens a timeline window (pulse until p_end,
   // busy until b_end, next grant allowed at nxt_grant).
   task automatic test_random();
      bit         pend[N];
      bit         prev[N];
      bit         r;
      bit         dropped;
      int         rr, id, nxt_grant, p_end, b_end, w, g, win, c, dcnt;
      logic [3:0] exp_pend;
      logic [3:0] exp_ack;
      logic       exp_pulse;
      logic       exp_busy;
      rr = N - 1; id = 0; nxt_grant = 0; p_end = -1; b_end = -1; dcnt = 0;
      for (int e = 0; e < 1500; e++) begin
         rst_n     = (e == 0) ? 1'b0 : ($urandom_range(0, 199) != 0);
         if ($urandom_range(0, 1) == 1) req = 4'($urandom_range(0, 15));
         cfg_width = 8'($urandom_range(0, 4));
         cfg_gap   = 8'($urandom_range(0, 3));
         drop_clr  = ($urandom_range(0, 49) == 0);
         @(posedge clk);
         exp_ack = '0;
         if (!rst_n) begin
            for (int k = 0; k < N; k++) begin pend[k] = 0; prev[k] = 0; end
            rr = N - 1; id = 0; dcnt = 0; nxt_grant = e + 1; p_end = -1; b_end = -1;
         end else begin
            win = -1;
            if (e >= nxt_grant) begin
               for (int k = 1; k <= N; k++) begin
                  c = (rr + k) % N;
                  if (win < 0 && pend[c]) win = c;
               end
            end
            dropped = 0;
            for (int k = 0; k < N; k++) begin
               r = req[k] && !prev[k];
               if (r && pend[k] && k != win) dropped = 1;
               if (k == win) pend[k] = r;
               else if (r) pend[k] = 1;
               prev[k] = req[k];
            end
            if (drop_clr) dcnt = 0;
            else if (dropped && dcnt < 65535) dcnt++;
            if (win >= 0) begin
               w = (cfg_width == 0) ? 1 : int'(cfg_width);
               g = int'(cfg_gap);
               rr = win; id = win; exp_ack[win] = 1'b1;
               p_end = e + w - 1; b_end = e + w + g - 1; nxt_grant = e + w + g + 1;
            end
         end
         #1;
         for (int k = 0; k < N; k++) exp_pend[k] = pend[k];
         exp_pulse = (e <= p_end);
         exp_busy  = (e <= b_end);
         checks++; if (pulse_out !== exp_pulse) begin errors++; $display("FAIL rand_pulse cyc%0d: got %b expected %b", e, pulse_out, exp_pulse); end
         checks++; if (busy !== exp_busy) begin errors++; $display("FAIL rand_busy cyc%0d: got %b expected %b", e, busy, exp_busy); end
         checks++; if (ack !== exp_ack) begin errors++; $display("FAIL rand_ack cyc%0d: got %b expected %b", e, ack, exp_ack); end
         checks++; if (pulse_id !== 2'(id)) begin errors++; $display("FAIL rand_id cyc%0d: got %0d expected %0d", e, pulse_id, id); end
         checks++; if (pending !== exp_pend) begin errors++; $display("FAIL rand_pending cyc%0d: got %b expected %b", e, pending, exp_pend); end
         checks++; if (drop_cnt !== 16'(dcnt)) begin errors++; $display("FAIL rand_drop_cnt cyc%0d: got %0d expected %0d", e, drop_cnt, dcnt); end
      end
      drop_clr = 1'b0;
      rst_n    = 1'b1;
   endtask

   task automatic test_saturate();
      rst_n = 1'b0; tick(); rst_n = 1'b1;
      cfg_width = 8'd255; cfg_gap = 8'd255; drop_clr = 1'b0;
      for (int i = 0; i < 70000; i++) begin
         req = (i % 2 == 1) ? 4'b0010 : 4'b0100;
         tick();
         if (i == 59999) begin
            checks++;
            if (drop_cnt < 16'd59000 || drop_cnt > 16'd60000) begin
               errors++; $display("FAIL sat_midway: got %0d expected within 59000..60000", drop_cnt);
            end
         end
      end
      checks++; if (drop_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_reach: got %h expected ffff", drop_cnt); end
      for (int i = 0; i < 10; i++) begin
         req = (i % 2 == 1) ? 4'b0010 : 4'b0100;
         tick();
      end
      checks++; if (drop_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_no_wrap: got %h expected ffff", drop_cnt); end
      req = 4'b0000;
   endtask

   // Safety net so the run always terminates
   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; req = '0; cfg_width = '0; cfg_gap = '0; drop_clr = 1'b0;
      lo_rst_n = 1'b0; lo_req = '0; lo_cfg_width = '0; lo_cfg_gap = '0; lo_drop_clr = 1'b0;
      test_reset();
      test_single();
      test_rr_order();
      test_drop();
      test_width();
      test_polarity_low();
      test_random();
      test_saturate();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
